// File: rtl/crc10_frame_chk.sv
// Streaming CRC checker: accumulates an MSB-first CRC over a multi-beat frame,
// reports the remainder with an optional compare, and keeps saturating stats.
module crc10_frame_chk #(
    parameter int                 DATA_W = 16,
    parameter int                 CRC_W  = 10,
    parameter logic [CRC_W-1:0]   POLY   = 10'h233,
    parameter logic [CRC_W-1:0]   INIT   = 10'h000,
    parameter int                 CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic              in_chk_en,
    input  logic [CRC_W-1:0]  in_exp_crc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc,
    output logic              out_err,
    output logic [CNT_W-1:0]  frm_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRAME  = 2'd1,
        RESULT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [CRC_W-1:0]  out_crc_q, out_crc_d;
    logic              out_err_q, out_err_d;
    logic [CNT_W-1:0]  frm_q, err_q, drop_q;

    logic              acc;
    logic              in_frame;
    logic              use_beat;
    logic              done;
    logic              drop_inc;
    logic              err_now;
    logic [CRC_W-1:0]  seed;
    logic [CRC_W-1:0]  stepped;

    function automatic logic [CRC_W-1:0] crc_step(
        input logic [CRC_W-1:0]  r,
        input logic [DATA_W-1:0] d
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = r;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    // A sof beat always restarts from INIT, even when it aborts a frame.
    assign acc      = in_valid & in_ready;
    assign in_frame = (state_q == FRAME);
    assign use_beat = acc & (in_sof | in_frame);
    assign seed     = (in_frame & ~in_sof) ? crc_q : INIT;
    assign stepped  = crc_step(seed, in_data);
    assign done     = use_beat & in_eof;
    assign err_now  = in_chk_en & (stepped != in_exp_crc);
    assign drop_inc = acc & ((state_q == IDLE & ~in_sof) |
                             (in_frame & in_sof));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            out_crc_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            out_crc_q <= out_crc_d;
            out_err_q <= out_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        out_crc_d = out_crc_q;
        out_err_d = out_err_q;
        unique case (state_q)
            IDLE, FRAME: begin
                if (use_beat) begin
                    crc_d   = stepped;
                    state_d = in_eof ? RESULT : FRAME;
                end
                if (done) begin
                    out_crc_d = stepped;
                    out_err_d = err_now;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_d = IDLE;
                    crc_d   = INIT;
                end
            end
            default: begin
                state_d = IDLE;
                crc_d   = INIT;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q != RESULT);
        out_valid = (state_q == RESULT);
        out_crc   = out_crc_q;
        out_err   = out_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q  <= '0;
            err_q  <= '0;
            drop_q <= '0;
        end else if (clr) begin
            frm_q  <= '0;
            err_q  <= '0;
            drop_q <= '0;
        end else begin
            if (done && frm_q != '1)
                frm_q <= frm_q + CNT_W'(1);
            if (done && err_now && err_q != '1)
                err_q <= err_q + CNT_W'(1);
            if (drop_inc && drop_q != '1)
                drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign frm_cnt  = frm_q;
    assign err_cnt  = err_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_crc10_frame_chk.sv
// Directed plus randomized bench for crc10_frame_chk; CRC reference is
// polynomial long division of the frame bitstream by x^10+x^9+x^5+x^4+x+1.
module tb_crc10_frame_chk;

    localparam int DW = 16;
    localparam int CW = 10;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_sof = 1'b0;
    logic          in_eof = 1'b0;
    logic          in_chk_en = 1'b0;
    logic [CW-1:0] in_exp_crc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_crc;
    logic          out_err;
    logic [NW-1:0] frm_cnt, err_cnt, drop_cnt;

    int checks = 0;
    int failures = 0;
    int m_frm = 0, m_err = 0, m_drop = 0;

    crc10_frame_chk dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof), .in_chk_en(in_chk_en),
        .in_exp_crc(in_exp_crc), .out_valid(out_valid),
        .out_ready(out_ready), .out_crc(out_crc), .out_err(out_err),
        .frm_cnt(frm_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Remainder of M(x)*x^10 mod G(x) for the concatenated frame bits.
    function automatic logic [CW-1:0] ref_crc(input logic [DW-1:0] w[$]);
        int unsigned rem;
        bit bits[$];
        rem = 0;
        foreach (w[k])
            for (int i = DW - 1; i >= 0; i--) bits.push_back(w[k][i]);
        repeat (CW) bits.push_back(1'b0);
        foreach (bits[k]) begin
            rem = (rem << 1) | int'(bits[k]);
            if (rem & 32'h400) rem = rem ^ 32'h633;
        end
        return rem[CW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic s, input logic e,
                        input logic c, input logic [CW-1:0] x);
        bit ok;
        ok = 0;
        in_valid = 1'b1; in_data = d; in_sof = s; in_eof = e;
        in_chk_en = c; in_exp_crc = x;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (in_ready) ok = 1;
            tick();
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_frm"}, 64'(frm_cnt), 64'(m_frm));
        chk({tag, "_err"}, 64'(err_cnt), 64'(m_err));
        chk({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consume_valid", 64'(out_valid), 64'd0);
        chk("consume_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic run_frame(input string tag, input logic [DW-1:0] w[$],
                             input logic c, input logic [CW-1:0] x,
                             input int gap, output logic [CW-1:0] r);
        logic e;
        r = ref_crc(w);
        e = c & (r != x);
        foreach (w[k]) begin
            beat(w[k], k == 0, k == w.size() - 1, c, x);
            if (k != w.size() - 1) repeat (gap) tick();
        end
        m_frm++;
        if (e) m_err++;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_crc"}, 64'(out_crc), 64'(r));
        chk({tag, "_oerr"}, 64'(out_err), 64'(e));
        chk_cnt(tag);
        consume();
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [CW-1:0] r, hold_crc;
        logic          hold_err;

        #2;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_crc", 64'(out_crc), 64'd0);
        chk("rst_err", 64'(out_err), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk_cnt("rst");
        tick();
        rst_n = 1'b1;
        tick();

        q = '{16'h0001};
        run_frame("t1", q, 1'b1, 10'h233, 0, r);
        chk("t1_const", 64'(r), 64'h233);

        q = '{16'h0002};
        run_frame("t2a", q, 1'b1, 10'h254, 0, r);
        chk("t2a_const", 64'(r), 64'h255);
        run_frame("t2b", q, 1'b0, 10'h254, 0, r);

        q = '{16'h0000, 16'h0000, 16'h0001};
        run_frame("t3", q, 1'b1, 10'h233, 2, r);
        chk("t3_const", 64'(r), 64'h233);

        // Result held under back-pressure while a new beat waits.
        beat(16'h0002, 1'b1, 1'b1, 1'b0, 10'h0);
        m_frm++;
        hold_crc = out_crc;
        hold_err = out_err;
        chk("t4_crc0", 64'(hold_crc), 64'h255);
        in_valid = 1'b1; in_data = 16'h0001; in_sof = 1'b1; in_eof = 1'b1;
        in_chk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t4_ready", 64'(in_ready), 64'd0);
            chk("t4_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_crc", 64'(out_crc), 64'(hold_crc));
            chk("t4_hold_err", 64'(out_err), 64'(hold_err));
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_hs_valid", 64'(out_valid), 64'd0);
        chk("t4_frm_noacc", 64'(frm_cnt), 64'(m_frm));
        tick();
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        m_frm++;
        chk("t4_late_valid", 64'(out_valid), 64'd1);
        chk("t4_late_crc", 64'(out_crc), 64'h233);
        chk_cnt("t4");
        consume();

        beat(16'h1234, 1'b0, 1'b0, 1'b0, 10'h0);
        m_drop++;
        chk("t5_nosof_valid", 64'(out_valid), 64'd0);
        chk_cnt("t5a");
        beat(16'hBEEF, 1'b1, 1'b0, 1'b0, 10'h0);
        beat(16'h0002, 1'b1, 1'b1, 1'b1, 10'h255);
        m_drop++;
        m_frm++;
        chk("t5_restart_crc", 64'(out_crc), 64'h255);
        chk("t5_restart_err", 64'(out_err), 64'd0);
        chk("t5_drop_const", 64'(drop_cnt), 64'd2);
        chk_cnt("t5b");
        consume();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_frm = 0; m_err = 0; m_drop = 0;
        chk_cnt("t5_clr");

        for (int f = 0; f < 25; f++) begin
            int n;
            logic c;
            logic [CW-1:0] x;
            q = {};
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) q.push_back(DW'($urandom));
            c = 1'($urandom);
            x = $urandom_range(0, 1) ? ref_crc(q) : CW'($urandom);
            run_frame("rnd", q, c, x, $urandom_range(0, 3), r);
        end

        beat(16'h00FF, 1'b1, 1'b0, 1'b0, 10'h0);
        rst_n = 1'b0;
        #1;
        chk("t6a_valid", 64'(out_valid), 64'd0);
        chk("t6a_ready", 64'(in_ready), 64'd1);
        m_frm = 0; m_err = 0; m_drop = 0;
        chk_cnt("t6a");
        tick();
        rst_n = 1'b1;
        tick();
        q = '{16'h0001};
        run_frame("t6a_next", q, 1'b1, 10'h233, 0, r);

        beat(16'h0002, 1'b1, 1'b1, 1'b1, 10'h0);
        chk("t6b_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6b_valid", 64'(out_valid), 64'd0);
        chk("t6b_ready", 64'(in_ready), 64'd1);
        chk("t6b_crc", 64'(out_crc), 64'd0);
        m_frm = 0; m_err = 0; m_drop = 0;
        chk_cnt("t6b");
        tick();
        rst_n = 1'b1;
        tick();
        run_frame("t6b_next", q, 1'b1, 10'h233, 0, r);
        chk("t6b_const", 64'(r), 64'h233);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
